decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, handshaked instruction decode stage; successor to the combinational processor decoder.
- Accepts 32-bit ARM-style instructions on a valid/ready input and decodes them into the datapath control bundle.
- Presents the decoded result on a valid/ready output register.
- Adds multi-cycle MUL sequencing, BL link, illegal-op detection, flush, and a retire counter.
- Sits between fetch and execute.

Parameters:
- MUL_LAT, 3: cycles from MUL accept to out_valid; must be >=1.
- CNT_W, 16: width of the retire counter.
- LINK_REG, 4'd14: destination register forced for BL.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discards the held or in-flight instruction.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  instruction word.
- out_valid  out  1  decoded bundle is valid.
- out_ready  in  1  consumer takes the bundle.
- RegW, MemW, MemtoReg, ALUSrc, PCS, NoWrite  out  1 each  control bits.
- ImmSrc, RegSrc, FlagW  out  2 each  control fields.
- ALUControl  out  3  ALU operation select.
- rd  out  4  destination register.
- is_mul  out  1  bundle is a MUL.
- illegal  out  1  unsupported encoding.
- retired  out  CNT_W  count of out_valid&out_ready events.

Behaviour:
- Fields: Op=instr[27:26]; Funct=instr[25:20]; cmd=Funct[4:1]; S=Funct[0]; MUL when Op=00, Funct[5:1]=00000, instr[7:4]=1001.
- Op=00, data processing: RegW=1, ALUSrc=Funct[5], ImmSrc=00, RegSrc=00. ALUControl by cmd:
  - ADD 0100 -> 000; SUB 0010 -> 001; AND 0000 -> 010; ORR 1100 -> 011; MOV 1101 -> 100; MUL -> 101.
  - CMP 1010 -> 001 with NoWrite=1, RegW=0.
  - Any other cmd -> illegal.
  - FlagW[1]=S; FlagW[0]=S&(ADD|SUB|CMP).
  - rd=instr[15:12], except MUL uses rd=instr[19:16].
- Op=01, memory: ALUSrc=1, ImmSrc=01. ALUControl=000 if Funct[3] (U) else 001.
  - LDR (Funct[0]=1): RegW=1, MemtoReg=1, RegSrc=00.
  - STR: MemW=1, RegW=0, RegSrc=10.
  - FlagW=00.
- Op=10, branch: PCS=1, ALUSrc=1, ImmSrc=10, RegSrc=01, ALUControl=000. If Funct[4] (BL): RegW=1, rd=LINK_REG.
- Op=11: illegal.
- Illegal bundle: illegal=1, RegW=MemW=PCS=0, FlagW=00. It still flows through the handshake.
- PCS also =1 when RegW=1 and rd=15.
- FSM states:
  - IDLE: output register empty.
  - WAIT: MUL countdown running.
  - FULL: output register holds a bundle.
- in_ready = !reset & !flush & (IDLE | (FULL & out_ready)). Accept = in_valid & in_ready. A bundle is always decoded and registered on the accept edge.
- IDLE/FULL on accept:
  - Non-MUL, or MUL with MUL_LAT=1 -> FULL.
  - MUL with MUL_LAT>1 -> WAIT, cnt=MUL_LAT-1.
- FULL without accept: out_ready=1 -> IDLE; out_ready=0 -> FULL, and the bundle holds stable.
- WAIT: cnt decrements each cycle; when cnt=1 -> FULL. in_ready=0 throughout WAIT.
- out_valid = (state==FULL).
- Latency: non-MUL out_valid 1 cycle after the accept edge; MUL out_valid MUL_LAT cycles after it.
- Simultaneous retire+accept in FULL: the new bundle replaces the old in the same edge, giving back-to-back throughput of 1/cycle.
- flush (any state): next state IDLE, cnt=0, no accept that cycle, retired unchanged. flush beats out_ready.
- retired increments on out_valid&out_ready and saturates at all-ones.
- Reset:
  - State IDLE, cnt=0, retired=0.
  - All control outputs, rd, is_mul, illegal = 0; out_valid=0.
  - in_ready=0 while reset is asserted.
  - Reset mid-WAIT drops the MUL.

Test Plan:
- ADD R1,R2,R3 (E0821003), out_ready=1 -> next cycle: out_valid=1, ALUControl=000, RegW=1, ALUSrc=0, FlagW=00, rd=1; retired=1.
- ADDS R1,R2,#100 (E2921064), then ORR (E1821003) back-to-back -> consecutive valid cycles: first ALUSrc=1, FlagW=11; then ALUControl=011, FlagW=00.
- MUL R1,R2,R3 (E0010392), MUL_LAT=3 -> in_ready=0 for 2 cycles; out_valid on the 3rd cycle with ALUControl=101, is_mul=1, rd=1.
- STR (E5821004) with out_ready=0 for 4 cycles -> bundle stable with MemW=1, RegW=0, RegSrc=10, ImmSrc=01; in_ready=0 until out_ready=1.
- BL (EB000100) -> PCS=1, RegW=1, rd=14, ImmSrc=10. Op=11 word (EC000000) -> illegal=1, RegW=0.
- flush asserted during MUL WAIT -> next cycle state IDLE, out_valid=0, retired unchanged. With CNT_W=2, 5 retires -> retired=3.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered, handshaked ARM-style instruction decode stage
// Decodes on accept into an output register; MUL holds the slot for MUL_LAT cycles.
module decode_stage #(
  parameter int         MUL_LAT  = 3,
  parameter int         CNT_W    = 16,
  parameter logic [3:0] LINK_REG = 4'd14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             RegW,
  output logic             MemW,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic             PCS,
  output logic             NoWrite,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic [1:0]       FlagW,
  output logic [2:0]       ALUControl,
  output logic [3:0]       rd,
  output logic             is_mul,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FULL} state_t;

  typedef struct packed {
    logic       reg_w;
    logic       mem_w;
    logic       memto_reg;
    logic       alu_src;
    logic       pcs;
    logic       no_write;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] flag_w;
    logic [2:0] alu_control;
    logic [3:0] rd;
    logic       is_mul;
    logic       illegal;
  } bundle_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  bundle_t          bundle_q, bundle_d, dec;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             accept, retire;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       mul_enc;
  logic       bad;
  logic       unused_bits;

  assign op          = instr[27:26];
  assign funct       = instr[25:20];
  assign cmd         = funct[4:1];
  assign mul_enc     = (op == 2'b00) && (funct[5:1] == 5'b00000) && (instr[7:4] == 4'b1001);
  assign unused_bits = ^{instr[31:28], instr[11:8], instr[3:0]};

  always_comb begin
    dec    = '0;
    bad    = 1'b0;
    dec.rd = instr[15:12];
    unique case (op)
      2'b00: begin
        dec.reg_w   = 1'b1;
        dec.alu_src = funct[5];
        if (mul_enc) begin
          dec.alu_control = 3'b101;
          dec.is_mul      = 1'b1;
          dec.rd          = instr[19:16];
        end else begin
          unique case (cmd)
            4'b0100: dec.alu_control = 3'b000;
            4'b0010: dec.alu_control = 3'b001;
            4'b0000: dec.alu_control = 3'b010;
            4'b1100: dec.alu_control = 3'b011;
            4'b1101: dec.alu_control = 3'b100;
            4'b1010: begin
              dec.alu_control = 3'b001;
              dec.no_write    = 1'b1;
              dec.reg_w       = 1'b0;
            end
            default: bad = 1'b1;
          endcase
        end
        dec.flag_w = {funct[0],
                      funct[0] & (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)};
      end
      2'b01: begin
        dec.alu_src     = 1'b1;
        dec.imm_src     = 2'b01;
        dec.alu_control = funct[3] ? 3'b000 : 3'b001;
        if (funct[0]) begin
          dec.reg_w     = 1'b1;
          dec.memto_reg = 1'b1;
        end else begin
          dec.mem_w   = 1'b1;
          dec.reg_src = 2'b10;
        end
      end
      2'b10: begin
        dec.pcs     = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm_src = 2'b10;
        dec.reg_src = 2'b01;
        if (funct[4]) begin
          dec.reg_w = 1'b1;
          dec.rd    = LINK_REG;
        end
      end
      default: bad = 1'b1;
    endcase
    // Illegal words keep only rd so the slot is traceable; all side effects are suppressed.
    if (bad) begin
      dec         = '0;
      dec.rd      = instr[15:12];
      dec.illegal = 1'b1;
    end
    if (dec.reg_w && dec.rd == 4'hF) dec.pcs = 1'b1;
  end

  assign in_ready = !reset && !flush &&
                    (state_q == S_IDLE || (state_q == S_FULL && out_ready));
  assign accept   = in_valid && in_ready;
  assign retire   = (state_q == S_FULL) && out_ready && !flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bundle_d  = bundle_q;
    retired_d = retired_q;
    if (retire && retired_q != {CNT_W{1'b1}}) retired_d = retired_q + 1'b1;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_FULL: begin
          if (accept) begin
            bundle_d = dec;
            if (dec.is_mul && MUL_LAT > 1) begin
              state_d = S_WAIT;
              cnt_d   = CW'(MUL_LAT - 1);
            end else begin
              state_d = S_FULL;
            end
          end else if (state_q == S_FULL && out_ready) begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == CW'(1)) begin
            state_d = S_FULL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bundle_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bundle_q  <= bundle_d;
      retired_q <= retired_d;
    end
  end

  assign out_valid  = (state_q == S_FULL);
  assign RegW       = bundle_q.reg_w;
  assign MemW       = bundle_q.mem_w;
  assign MemtoReg   = bundle_q.memto_reg;
  assign ALUSrc     = bundle_q.alu_src;
  assign PCS        = bundle_q.pcs;
  assign NoWrite    = bundle_q.no_write;
  assign ImmSrc     = bundle_q.imm_src;
  assign RegSrc     = bundle_q.reg_src;
  assign FlagW      = bundle_q.flag_w;
  assign ALUControl = bundle_q.alu_control;
  assign rd         = bundle_q.rd;
  assign is_mul     = bundle_q.is_mul;
  assign illegal    = bundle_q.illegal;
  assign retired    = retired_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with a latency-level reference model
// Directed test-plan words first, then random traffic; a CNT_W=2 instance checks saturation.
module tb_decode_stage;
  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid;
  logic        RegW, MemW, MemtoReg, ALUSrc, PCS, NoWrite, is_mul, illegal;
  logic [1:0]  ImmSrc, RegSrc, FlagW;
  logic [2:0]  ALUControl;
  logic [3:0]  rd;
  logic [15:0] retired;

  logic        flush2, in_valid2, out_ready2, in_ready2, out_valid2;
  logic [31:0] instr2;
  logic        RegW2, MemW2, MemtoReg2, ALUSrc2, PCS2, NoWrite2, is_mul2, illegal2;
  logic [1:0]  ImmSrc2, RegSrc2, FlagW2;
  logic [2:0]  ALUControl2;
  logic [3:0]  rd2;
  logic [1:0]  retired2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage #(.MUL_LAT(MUL_LAT), .CNT_W(16), .LINK_REG(4'd14)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .RegW(RegW), .MemW(MemW), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .PCS(PCS),
    .NoWrite(NoWrite), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .FlagW(FlagW),
    .ALUControl(ALUControl), .rd(rd), .is_mul(is_mul), .illegal(illegal), .retired(retired)
  );

  decode_stage #(.MUL_LAT(MUL_LAT), .CNT_W(2), .LINK_REG(4'd14)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .instr(instr2), .out_valid(out_valid2), .out_ready(out_ready2),
    .RegW(RegW2), .MemW(MemW2), .MemtoReg(MemtoReg2), .ALUSrc(ALUSrc2), .PCS(PCS2),
    .NoWrite(NoWrite2), .ImmSrc(ImmSrc2), .RegSrc(RegSrc2), .FlagW(FlagW2),
    .ALUControl(ALUControl2), .rd(rd2), .is_mul(is_mul2), .illegal(illegal2), .retired(retired2)
  );

  logic [20:0] dut_b;
  assign dut_b = {RegW, MemW, MemtoReg, ALUSrc, PCS, NoWrite, ImmSrc, RegSrc, FlagW,
                  ALUControl, rd, is_mul, illegal};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference decode written from the instruction-class rules.
  function automatic logic [20:0] ref_decode(input logic [31:0] w);
    logic rw, mw, mr, as, pc, nw, im, ill, flag_cmd;
    logic [1:0] isrc, rsrc, fw;
    logic [2:0] ac;
    logic [3:0] r, c;
    {rw, mw, mr, as, pc, nw, im, ill, flag_cmd} = '0;
    {isrc, rsrc, fw, ac} = '0;
    r = w[15:12];
    c = w[24:21];
    case (w[27:26])
      2'd0: begin
        as = w[25];
        if (w[25:21] == 5'd0 && w[7:4] == 4'd9) begin
          rw = 1; ac = 3'd5; im = 1; r = w[19:16];
        end else if (c == 4'd4)  begin rw = 1; ac = 3'd0; flag_cmd = 1; end
        else if (c == 4'd2)      begin rw = 1; ac = 3'd1; flag_cmd = 1; end
        else if (c == 4'd0)      begin rw = 1; ac = 3'd2; end
        else if (c == 4'd12)     begin rw = 1; ac = 3'd3; end
        else if (c == 4'd13)     begin rw = 1; ac = 3'd4; end
        else if (c == 4'd10)     begin nw = 1; ac = 3'd1; flag_cmd = 1; end
        else ill = 1;
        fw = {w[20], w[20] & flag_cmd};
      end
      2'd1: begin
        as = 1; isrc = 2'd1; ac = w[23] ? 3'd0 : 3'd1;
        if (w[20]) begin rw = 1; mr = 1; end
        else begin mw = 1; rsrc = 2'd2; end
      end
      2'd2: begin
        pc = 1; as = 1; isrc = 2'd2; rsrc = 2'd1;
        if (w[24]) begin rw = 1; r = 4'd14; end
      end
      default: ill = 1;
    endcase
    if (ill) begin
      {rw, mw, mr, as, pc, nw, im} = '0;
      {isrc, rsrc, fw, ac} = '0;
      r = w[15:12];
    end
    if (rw && r == 4'd15) pc = 1;
    return {rw, mw, mr, as, pc, nw, isrc, rsrc, fw, ac, r, im, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom % 6)
      0: w[27:26] = 2'd0;
      1: begin w[27:21] = 7'd0; w[7:4] = 4'd9; end
      2: w[27:26] = 2'd1;
      3: w[27:26] = 2'd2;
      4: w[27:26] = 2'd3;
      default: ;
    endcase
    return w;
  endfunction

  typedef struct {
    logic [20:0] b;
    int          due;
  } exp_t;

  exp_t  sb[$];
  int    cyc = 0;
  int    ret_model = 0;
  logic  rst_prev = 1'b1;

  always @(negedge clk) begin
    logic exp_ov, exp_ir;
    cyc++;
    exp_ov = (sb.size() > 0) && (cyc >= sb[0].due);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) check("bundle", 32'(dut_b), 32'(sb[0].b));
    if (rst_prev) check("reset_bundle", 32'(dut_b), 32'd0);
    check("retired", 32'(retired), 32'(ret_model));
    exp_ir = !reset && !flush && (sb.size() == 0 || (exp_ov && out_ready));
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    if (reset) begin
      sb.delete();
      ret_model = 0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (exp_ov && out_ready) begin
        void'(sb.pop_front());
        if (ret_model < 16'hFFFF) ret_model++;
      end
      if (in_valid && exp_ir) begin
        exp_t e;
        e.b   = ref_decode(instr);
        e.due = cyc + (e.b[1] ? MUL_LAT : 1);
        sb.push_back(e);
      end
    end
    rst_prev = reset;
  end

  int sat_model = 0;
  always @(negedge clk) begin
    check("retired_sat", 32'(retired2), 32'(sat_model));
    if (reset) sat_model = 0;
    else if (out_valid2 && out_ready2 && sat_model < 3) sat_model++;
  end

  task automatic send(input logic [31:0] w);
    bit got = 0;
    in_valid = 1'b1;
    instr    = w;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: got in_ready=0 want 1 for instr %h", w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; instr = '0;
    flush2 = 0; in_valid2 = 0; out_ready2 = 0; instr2 = '0;
    idle(3);
    reset = 0;
    out_ready = 1;
    idle(1);

    send(32'hE0821003);
    idle(2);
    send(32'hE2921064);
    send(32'hE1821003);
    idle(2);
    send(32'hE0010392);
    send(32'hE5821004);
    out_ready = 0;
    in_valid  = 1;
    instr     = 32'hEB000100;
    idle(4);
    out_ready = 1;
    send(32'hEB000100);
    send(32'hEC000000);
    idle(2);

    send(32'hE0010392);
    flush = 1;
    idle(1);
    flush = 0;
    idle(3);
    send(32'hE0010392);
    reset = 1;
    idle(1);
    reset = 0;
    idle(2);

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom % 4) != 0;
      instr     = rand_instr();
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 32) == 0;
      idle(1);
    end
    in_valid = 0; flush = 0; out_ready = 1;
    idle(6);

    instr2     = 32'hE0821003;
    in_valid2  = 1;
    out_ready2 = 1;
    idle(10);
    in_valid2 = 0;
    idle(3);
    @(negedge clk);
    check("sat_final", 32'(retired2), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
